// File: rtl/bram_port_arbiter_pkg.sv
// Shared types and the round-robin grant function for the BRAM port arbiter.
// rr_grant is combinational and sized for up to MAX_REQ requesters so other arbiters can reuse it.
package bram_port_arbiter_pkg;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  localparam int unsigned MAX_REQ = 4;
  localparam int unsigned PTR_W   = 2;

  // Scan from ptr upward, wrapping at n; the first valid index wins.
  function automatic logic [MAX_REQ-1:0] rr_grant(
    input logic [MAX_REQ-1:0] valid,
    input logic [PTR_W-1:0]   ptr,
    input int unsigned        n
  );
    logic [MAX_REQ-1:0] grant;
    logic               found;
    int unsigned        idx;
    grant = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < MAX_REQ; k++) begin
      if (k < n) begin
        idx = 32'(ptr) + k;
        if (idx >= n) begin
          idx = idx - n;
        end
        if (!found && valid[idx[PTR_W-1:0]]) begin
          grant[idx[PTR_W-1:0]] = 1'b1;
          found                 = 1'b1;
        end
      end
    end
    return grant;
  endfunction

endpackage

// File: rtl/bram_port_arbiter_rr.sv
// Round-robin arbiter: combinational one-hot grant plus index, pointer advances past the winner.
// Zero latency from valid to grant; the pointer holds whenever nothing is granted or en_i is low.
module rr_arbiter
  import bram_port_arbiter_pkg::*;
#(
  parameter  int unsigned N  = 3,
  localparam int unsigned IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  valid_i,
  input  logic          en_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] idx_o
);

  logic [IW-1:0]      ptr_q, ptr_d;
  logic [MAX_REQ-1:0] valid_ext;
  logic [PTR_W-1:0]   ptr_ext;

  always_comb begin
    valid_ext          = '0;
    valid_ext[N-1:0]   = valid_i;
    ptr_ext            = '0;
    ptr_ext[IW-1:0]    = ptr_q;
    grant_o            = N'(rr_grant(valid_ext, ptr_ext, N));
    idx_o              = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (grant_o[i]) begin
        idx_o = IW'(i);
      end
    end
    ptr_d = ptr_q;
    if (en_i && |grant_o) begin
      ptr_d = (idx_o == IW'(N-1)) ? '0 : idx_o + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/bram_port_arbiter.sv
// Shares one BRAM port among NREQ requesters with round-robin grants; zero-fills the RAM after reset.
// Grant is same-cycle, response strobe one cycle later; requests are held off (not dropped) while clearing.
module bram_port_arbiter
  import bram_port_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SCALE = 10,
  parameter int unsigned NREQ  = 3,
  parameter bit          CLEAR = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ-1:0]       req_we,
  input  logic [NREQ*SCALE-1:0] req_addr,
  input  logic [NREQ*WIDTH-1:0] req_wdata,
  output logic [NREQ-1:0]       req_ready,
  output logic [NREQ-1:0]       rsp_valid,
  output logic [WIDTH-1:0]      rsp_rdata,
  output logic                  ram_oe,
  output logic                  ram_we,
  output logic [SCALE-1:0]      ram_addr,
  output logic [WIDTH-1:0]      ram_wdata,
  input  logic [WIDTH-1:0]      ram_rdata,
  output logic                  busy_clear
);

  localparam int unsigned IW = $clog2(NREQ);

  state_e           state_q, state_d;
  logic             busy_clear_q;
  logic [SCALE-1:0] clr_cnt_q, clr_cnt_d;
  logic [NREQ-1:0]  rsp_valid_q;
  logic [NREQ-1:0]  grant;
  logic [IW-1:0]    gidx;
  logic             run;

  assign run = (state_q == ST_RUN);

  rr_arbiter #(
    .N (NREQ)
  ) u_rr (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid_i (req_valid & {NREQ{run}}),
    .en_i    (run),
    .grant_o (grant),
    .idx_o   (gidx)
  );

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    if (state_q == ST_CLEAR) begin
      clr_cnt_d = clr_cnt_q + 1'b1;
      if (clr_cnt_q == '1) begin
        state_d = ST_RUN;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= CLEAR ? ST_CLEAR : ST_RUN;
      busy_clear_q <= CLEAR;
      clr_cnt_q    <= '0;
      rsp_valid_q  <= '0;
    end else begin
      state_q      <= state_d;
      busy_clear_q <= (state_d == ST_CLEAR);
      clr_cnt_q    <= clr_cnt_d;
      rsp_valid_q  <= grant;
    end
  end

  // The clear sequence owns the port outright; otherwise the granted requester drives it.
  always_comb begin
    ram_oe    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (state_q == ST_CLEAR) begin
      ram_oe   = 1'b1;
      ram_we   = 1'b1;
      ram_addr = clr_cnt_q;
    end else if (|grant) begin
      ram_oe = 1'b1;
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (gidx == IW'(i)) begin
          ram_we    = req_we[i];
          ram_addr  = req_addr[i*SCALE +: SCALE];
          ram_wdata = req_wdata[i*WIDTH +: WIDTH];
        end
      end
    end
  end

  assign req_ready  = grant;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_rdata  = ram_rdata;
  assign busy_clear = busy_clear_q;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed bench for bram_port_arbiter with a behavioural 1-cycle write-through RAM (SCALE=4, NREQ=3).
module tb_bram_port_arbiter;

  localparam int W = 32;
  localparam int S = 4;
  localparam int N = 3;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic [N-1:0]   req_valid, req_we, req_ready, rsp_valid;
  logic [N*S-1:0] req_addr;
  logic [N*W-1:0] req_wdata;
  logic [W-1:0]   rsp_rdata, ram_wdata, ram_rdata;
  logic           ram_oe, ram_we, busy_clear;
  logic [S-1:0]   ram_addr;

  int n_pass  = 0;
  int n_total = 0;

  logic [W-1:0] mem [2**S];
  logic         ram_seeded = 1'b0;

  bram_port_arbiter #(
    .WIDTH (W),
    .SCALE (S),
    .NREQ  (N),
    .CLEAR (1'b1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .ram_oe     (ram_oe),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata),
    .busy_clear (busy_clear)
  );

  always #5 clk = ~clk;

  // RAM starts full of a non-zero pattern so the zero-fill is observable.
  always @(posedge clk) begin
    if (!ram_seeded) begin
      for (int i = 0; i < 2**S; i++) mem[i] <= 32'hA5A5_A5A5;
      ram_rdata  <= 32'hA5A5_A5A5;
      ram_seeded <= 1'b1;
    end else if (ram_oe) begin
      if (ram_we) begin
        mem[ram_addr] <= ram_wdata;
        ram_rdata     <= ram_wdata;
      end else begin
        ram_rdata <= mem[ram_addr];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
  endtask

  task automatic set_req(input int i, input logic we, input logic [S-1:0] a, input logic [W-1:0] d);
    req_valid[i]         = 1'b1;
    req_we[i]            = we;
    req_addr[i*S +: S]   = a;
    req_wdata[i*W +: W]  = d;
  endtask

  initial begin
    logic [2:0] e;
    logic [2:0] e_prev;
    req_valid = '0;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;
    #2 rst_n = 1'b0;
    @(negedge clk); #1;
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_busy", 32'(busy_clear), 32'h1);

    // All three request reads during the clear; they must be held off.
    set_req(0, 1'b0, 4'd7, 32'h0);
    set_req(1, 1'b0, 4'd8, 32'h0);
    set_req(2, 1'b0, 4'd9, 32'h0);
    rst_n = 1'b1;
    for (int k = 0; k < 16; k++) begin
      #1;
      chk("clr_busy", 32'(busy_clear), 32'h1);
      chk("clr_oe", 32'(ram_oe), 32'h1);
      chk("clr_we", 32'(ram_we), 32'h1);
      chk("clr_addr", 32'(ram_addr), 32'(k));
      chk("clr_wdata", ram_wdata, 32'h0);
      chk("clr_ready", 32'(req_ready), 32'h0);
      @(negedge clk);
    end

    for (int j = 0; j < 6; j++) begin
      #1;
      e = 3'b001 << (j % 3);
      chk("rr_ready", 32'(req_ready), 32'(e));
      chk("run_busy", 32'(busy_clear), 32'h0);
      if (j > 0) begin
        chk("rr_rsp_valid", 32'(rsp_valid), 32'(e_prev));
        chk("rr_rdata_cleared", rsp_rdata, 32'h0);
      end
      e_prev = e;
      @(negedge clk);
    end
    req_valid = '0;
    #1;
    chk("rr_last_rsp", 32'(rsp_valid), 32'h4);
    chk("rr_last_rdata", rsp_rdata, 32'h0);
    chk("idle_ready", 32'(req_ready), 32'h0);
    chk("idle_oe", 32'(ram_oe), 32'h0);

    @(negedge clk); req_valid = '0; set_req(0, 1'b1, 4'd5, 32'hDEAD_BEEF); #1;
    chk("w5_ready", 32'(req_ready), 32'h1);
    chk("w5_we", 32'(ram_we), 32'h1);
    chk("w5_addr", 32'(ram_addr), 32'h5);
    chk("w5_wdata", ram_wdata, 32'hDEAD_BEEF);

    @(negedge clk); req_valid = '0; set_req(1, 1'b0, 4'd5, 32'h0); #1;
    chk("w5_rsp", 32'(rsp_valid), 32'h1);
    chk("w5_rdata", rsp_rdata, 32'hDEAD_BEEF);
    chk("r5_ready", 32'(req_ready), 32'h2);

    @(negedge clk); req_valid = '0; set_req(2, 1'b1, 4'd3, 32'h1234_5678); #1;
    chk("r5_rsp", 32'(rsp_valid), 32'h2);
    chk("r5_rdata", rsp_rdata, 32'hDEAD_BEEF);
    chk("w3_ready", 32'(req_ready), 32'h4);
    chk("w3_we", 32'(ram_we), 32'h1);

    @(negedge clk); req_valid = '0; req_we = '0; set_req(0, 1'b0, 4'd3, 32'h0); #1;
    chk("w3_rsp", 32'(rsp_valid), 32'h4);
    chk("w3_rdata", rsp_rdata, 32'h1234_5678);
    chk("r3_ready", 32'(req_ready), 32'h1);

    // Pointer is 1 here; requesters 0 and 2 valid should alternate starting with 2.
    @(negedge clk); set_req(2, 1'b0, 4'd5, 32'h0); #1;
    chk("r3_rsp", 32'(rsp_valid), 32'h1);
    chk("r3_rdata", rsp_rdata, 32'h1234_5678);
    chk("p1_ready_a", 32'(req_ready), 32'h4);
    chk("p1_addr_a", 32'(ram_addr), 32'h5);

    @(negedge clk); #1;
    chk("p1_ready_b", 32'(req_ready), 32'h1);
    chk("p1_rsp_a", 32'(rsp_valid), 32'h4);
    chk("p1_rdata_a", rsp_rdata, 32'hDEAD_BEEF);
    chk("p1_addr_b", 32'(ram_addr), 32'h3);

    @(negedge clk); #1;
    chk("p1_ready_c", 32'(req_ready), 32'h4);
    chk("p1_rsp_b", 32'(rsp_valid), 32'h1);
    chk("p1_rdata_b", rsp_rdata, 32'h1234_5678);

    @(negedge clk); req_valid = '0; set_req(0, 1'b0, 4'd3, 32'h0); #1;
    chk("pre_rst_ready", 32'(req_ready), 32'h1);
    chk("p1_rsp_c", 32'(rsp_valid), 32'h4);

    @(negedge clk); #1;
    chk("pre_rst_rsp", 32'(rsp_valid), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rsp", 32'(rsp_valid), 32'h0);
    chk("mid_rst_busy", 32'(busy_clear), 32'h1);
    chk("mid_rst_ready", 32'(req_ready), 32'h0);
    chk("mid_rst_addr", 32'(ram_addr), 32'h0);
    chk("mid_rst_we", 32'(ram_we), 32'h1);
    rst_n = 1'b1;

    @(negedge clk); #1;
    chk("reclr_busy", 32'(busy_clear), 32'h1);
    chk("reclr_addr", 32'(ram_addr), 32'h1);

    repeat (15) @(negedge clk);
    #1;
    chk("reclr_done_busy", 32'(busy_clear), 32'h0);
    chk("reclr_held_ready", 32'(req_ready), 32'h1);

    @(negedge clk); req_valid = '0; #1;
    chk("reclr_rsp", 32'(rsp_valid), 32'h1);
    chk("reclr_rdata", rsp_rdata, 32'h0);
    chk("reclr_idle_ready", 32'(req_ready), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
